rr_grant_encoder: RTL
=====================

// Module: rr_grant_encoder
// PURPOSE
//   Round-robin arbiter that emits the winning requester as a registered binary
//   index with a valid/ready handshake. Sits directly upstream of onehot_decoder:
//   gnt_idx_o drives the decoder input, and the decoder output forms the grant vector.
//   Grants are held stable until the consumer accepts them.
// PARAMETERS
//   REQ_NUM   8                   number of requesters; any value >= 2, need not be 2^n
//   IDX_W     $clog2(REQ_NUM)     width of grant index; default 3 matches decoder INPUT_W
// PORTS
//   clk         in   1         single clock, all state updates on rising edge
//   rst         in   1         synchronous, active-high reset
//   req_i       in   REQ_NUM   request vector, bit n = requester n
//   gnt_idx_o   out  IDX_W     binary index of granted requester, registered
//   gnt_vld_o   out  1         grant valid, registered
//   gnt_rdy_i   in   1         consumer accepts grant; handshake = gnt_vld_o & gnt_rdy_i
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE, ptr=0, gnt_idx_o=0, gnt_vld_o=0.
//     Takes priority over every other event, including a handshake in the same cycle.
//   Pick function: the first set bit of req_i, searching from ptr upward with wrap
//     at REQ_NUM-1 -> 0. No set bit -> no pick.
//   FSM states: IDLE, GRANT.
//   IDLE: if |req_i, register the pick into gnt_idx_o, set gnt_vld_o=1, go to GRANT.
//     Otherwise stay in IDLE with gnt_vld_o=0 and gnt_idx_o unchanged.
//     Latency is 1 cycle: req seen at edge k gives gnt_vld_o=1 after edge k.
//   GRANT without handshake: gnt_idx_o and gnt_vld_o are held unchanged.
//     The grant is not retracted even if req_i[gnt_idx_o] drops.
//   GRANT with handshake: ptr <= gnt_idx_o+1, wrapping to 0 when gnt_idx_o == REQ_NUM-1.
//     The same cycle runs a pick with that new ptr value on the current req_i:
//     - hit: load the new index, keep gnt_vld_o=1, stay in GRANT (back-to-back,
//       one grant per cycle at full throughput);
//     - miss: gnt_vld_o <= 0, go to IDLE.
//   ptr changes only on a handshake, never on idle cycles, so fairness holds.
//   gnt_idx_o is always < REQ_NUM. Unused index codes are never produced when
//     REQ_NUM is not a power of two.
//   gnt_rdy_i is a don't-care while gnt_vld_o=0.
//   Reset mid-grant: the grant is dropped with no handshake counted; ptr returns to 0.
//   All outputs come straight from flops; there is no combinational path from input to output.
// STRUCTURE
//   Shared package/header: FSM state localparams (ST_IDLE=1'b0, ST_GRANT=1'b1) and a
//     clog2 constant function reused by decoder/encoder blocks.
//   Sub-module rr_pick (combinational): inputs req, ptr; outputs hit and idx.
//     Implemented as a double-width rotate and priority search.
//   Top level holds the FSM, the ptr register and the output registers.
//   Integration: gnt_idx_o -> onehot_decoder.i (INPUT_W=IDX_W).
// TESTING
//   1 Reset: rst=1 for 2 cycles with req_i=8'hFF -> gnt_vld_o=0, gnt_idx_o=0; after
//     release, gnt_vld_o=1 with idx=0 one cycle later.
//   2 Rotation: req_i=8'hFF, gnt_rdy_i=1 held -> idx sequence 0,1,...,7,0 on
//     consecutive cycles, gnt_vld_o held at 1.
//   3 Hold/backpressure: req_i=8'h24, gnt_rdy_i=0 for 5 cycles -> idx=2 stable and
//     vld=1; then rdy=1 for 1 cycle -> next idx=5.
//   4 Wrap and sparse requests: ptr=6 via a prior grant of 5, req_i=8'h09 -> idx=0;
//     after its handshake -> idx=3.
//   5 Non-power-of-two: REQ_NUM=5, req_i=5'h1F, rdy=1 -> idx 0..4,0; index 5..7 never
//     appears; the decoder output is exactly one-hot.
//   6 Request drop and mid-op reset: grant idx=3, clear req_i with rdy=0 -> grant held;
//     assert rst -> vld=0 next edge, ptr=0.

Source files
------------

// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the grant encoder: FSM state encoding and a
// constant clog2 helper also used by the matching decoder blocks.
package rr_grant_encoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_encoder_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping past REQ_NUM-1, found by a priority search over {req, req}.
module rr_pick
  import rr_grant_encoder_pkg::*;
#(
  parameter int REQ_NUM = 8,
  parameter int IDX_W   = clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*REQ_NUM-1:0] dbl;
  int                   pos;

  always_comb begin
    dbl   = {req_i, req_i};
    hit_o = 1'b0;
    pos   = 0;
    // Descending scan so the lowest qualifying position wins.
    for (int i = 2*REQ_NUM - 1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr_i)) && (i < int'(ptr_i) + REQ_NUM)) begin
        hit_o = 1'b1;
        pos   = i;
      end
    end
    if (pos >= REQ_NUM) begin
      pos = pos - REQ_NUM;
    end
    idx_o = IDX_W'(pos);
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing a registered binary grant index with a
// valid/ready handshake; the pointer advances only on an accepted grant.
//
//   state    | meaning
//   ST_IDLE  | no grant outstanding, waiting for any request
//   ST_GRANT | gnt_idx_o valid and held until gnt_rdy_i accepts it
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int REQ_NUM = 8,
  parameter int IDX_W   = clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o,
  input  logic               gnt_rdy_i
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;

  logic             hs;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    hs       = vld_q & gnt_rdy_i;
    ptr_inc  = (idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : idx_q + 1'b1;
    // On a handshake the pick already uses the advanced pointer.
    pick_ptr = hs ? ptr_inc : ptr_q;
  end

  rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (pick_ptr),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
        if (pick_hit) begin
          idx_d   = pick_idx;
          vld_d   = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (hs) begin
          ptr_d = ptr_inc;
          if (pick_hit) begin
            idx_d = pick_idx;
          end else begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = vld_q;

endmodule
